// File: rtl/router_fifo_ctrl.sv
// Router FIFO control: header address latch, write-enable steering,
// per-port valid flags and unread-port timeout flush.
module router_fifo_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [1:0]    addr_q;
  logic [2:0]    vld;
  logic [2:0]    rd;
  logic [2:0]    sr_q;
  logic [CW-1:0] cnt_q [3];

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  assign soft_reset_0 = sr_q[0];
  assign soft_reset_1 = sr_q[1];
  assign soft_reset_2 = sr_q[2];

  // Address 2'b11 means no port selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 2'b11;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  // Count consecutive valid-but-unread edges; pulse and restart on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!vld[i] || rd[i]) begin
          cnt_q[i] <= '0;
          sr_q[i]  <= 1'b0;
        end else if (cnt_q[i] == LAST) begin
          cnt_q[i] <= '0;
          sr_q[i]  <= 1'b1;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
          sr_q[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo_ctrl.sv
// Directed bench for router_fifo_ctrl: table of decode vectors plus
// hand-written timeout sequences.
module tb_router_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  router_fifo_ctrl #(.TIMEOUT(30), .CW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2)
  );

  typedef struct {
    logic       da;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sr();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  function automatic logic [2:0] vld();
    return {vld_out_2, vld_out_1, vld_out_0};
  endfunction

  initial begin
    reset = 1'b1; detect_add = 1'b0; data_in = 2'b00;
    write_enb_reg = 1'b1;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b111;
    {empty_2, empty_1, empty_0} = 3'b010;
    {full_2, full_1, full_0} = 3'b111;

    // Reset state
    tick();
    #1;
    chk("rst_sr", 32'(sr()), 32'h0);
    chk("rst_we", 32'(write_enb), 32'h0);
    chk("rst_ff", 32'(fifo_full), 32'h0);
    chk("rst_vld", 32'(vld()), 32'h5);
    reset = 1'b0;
    tick();

    //            da  din    wr  full    empty   we      ff  vld
    tbl[0]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{1'b1, 2'b01, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 3'b111};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b101, 3'b010, 1'b1, 3'b010};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b010, 3'b010, 1'b0, 3'b101};
    tbl[4]  = '{1'b1, 2'b11, 1'b1, 3'b000, 3'b000, 3'b010, 1'b0, 3'b111};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b111};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 3'b111, 3'b110, 3'b000, 1'b0, 3'b001};
    tbl[7]  = '{1'b1, 2'b10, 1'b1, 3'b001, 3'b011, 3'b001, 1'b1, 3'b100};
    tbl[8]  = '{1'b0, 2'b00, 1'b1, 3'b011, 3'b000, 3'b100, 1'b0, 3'b111};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 3'b111};
    tbl[11] = '{1'b1, 2'b01, 1'b1, 3'b000, 3'b000, 3'b100, 1'b0, 3'b111};

    for (int i = 0; i < 12; i++) begin
      detect_add = tbl[i].da;
      data_in = tbl[i].din;
      write_enb_reg = tbl[i].wr;
      {full_2, full_1, full_0} = tbl[i].full;
      {empty_2, empty_1, empty_0} = tbl[i].empty;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(write_enb), 32'(tbl[i].exp_we));
      chk($sformatf("vec%0d_ff", i), 32'(fifo_full), 32'(tbl[i].exp_ff));
      chk($sformatf("vec%0d_vld", i), 32'(vld()), 32'(tbl[i].exp_vld));
      tick();
    end

    // Same-cycle address change uses the old address
    detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b0;
    tick();
    data_in = 2'b10; write_enb_reg = 1'b1;
    #1;
    chk("same_cyc_old", 32'(write_enb), 32'h1);
    tick();
    detect_add = 1'b0;
    #1;
    chk("same_cyc_new", 32'(write_enb), 32'h4);

    // Port 2 stall, ports 0/1 valid but read; pulses after edges 30 and 60
    write_enb_reg = 1'b0;
    {empty_2, empty_1, empty_0} = 3'b000;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b011;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      chk($sformatf("stall2_e%0d", k), 32'(sr()),
          (k == 30 || k == 60) ? 32'h4 : 32'h0);
    end

    // Read on edge 29 suppresses the pulse and restarts the count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      read_enb_2 = (k == 29);
      tick();
      chk($sformatf("rd29_e%0d", k), 32'(sr()),
          (k == 59) ? 32'h4 : 32'h0);
    end
    read_enb_2 = 1'b1;

    // Reset mid-count on port 0
    {empty_2, empty_1, empty_0} = 3'b110;
    read_enb_0 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    chk("midrst_pre", 32'(sr()), 32'h0);
    reset = 1'b1;
    tick();
    chk("midrst_in", 32'(sr()), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("midrst_e%0d", k), 32'(sr()),
          (k == 30) ? 32'h1 : 32'h0);
    end

    // Simultaneous timeouts on all ports
    {empty_2, empty_1, empty_0} = 3'b000;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("all_e%0d", k), 32'(sr()),
          (k == 30) ? 32'h7 : 32'h0);
    end

    // Pulse in flight drops when reset is applied
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) tick();
    chk("pulse_up", 32'(sr()), 32'h7);
    reset = 1'b1;
    tick();
    chk("pulse_rst", 32'(sr()), 32'h0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fifo_ctrl.md
# router_fifo_ctrl

Control block between the router's input FSM and the three output FIFOs of the 1x3 router. It latches the destination address from each packet header and steers the write enable and the full flag to and from the selected FIFO. It also drives the per-port valid outputs and times out unread ports, issuing a one-cycle soft_reset that flushes the stalled FIFO.

## Interface
Parameters:
- TIMEOUT, 30, consecutive valid-but-unread cycles before a port's soft_reset fires.
- CW, 5, timeout counter width; must satisfy 2^CW >= TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  header byte present; capture address this cycle.
- data_in  in  2  destination address bits from the header byte (00, 01, 10 valid; 11 invalid).
- write_enb_reg  in  1  FSM request to write the current byte into the addressed FIFO.
- read_enb_0/1/2  in  1 each  downstream read strobes per port.
- empty_0/1/2  in  1 each  FIFO empty flags.
- full_0/1/2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enable; bit i selects FIFO i.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out_0/1/2  out  1 each  port has data (~empty_i).
- soft_reset_0/1/2  out  1 each  one-cycle FIFO flush pulse on timeout.

## Operation
- Address register addr_q:
  - On detect_add=1, addr_q <= data_in.
  - Otherwise addr_q holds.
  - Reset value 2'b11 (invalid).
- write_enb (combinational):
  - When write_enb_reg=1, write_enb is the one-hot decode of addr_q (00->001, 01->010, 10->100).
  - addr_q=11 or write_enb_reg=0 gives 000.
- fifo_full (combinational): full_<addr_q>; 0 when addr_q=11.
- vld_out_i = ~empty_i (combinational).
- Timeout channel i (three identical, independent instances), evaluated at each rising edge:
  - vld_out_i=0 or read_enb_i=1: cnt_i <= 0, soft_reset_i <= 0.
  - Else, if cnt_i == TIMEOUT-1: soft_reset_i <= 1, cnt_i <= 0.
  - Else: cnt_i <= cnt_i+1, soft_reset_i <= 0.
- Reset: cnt_i=0, soft_reset_i=0, addr_q=11. Combinational outputs then follow their inputs: write_enb=000, fifo_full=0, vld_out_i=~empty_i.

## Timing
- write_enb, fifo_full and vld_out_i are combinational from current inputs and addr_q; zero latency.
- New address latency:
  - A detect_add at edge N affects write_enb and fifo_full from cycle N+1.
  - detect_add and write_enb_reg high in the same cycle: the decode uses the old addr_q.
  - The FSM issues detect_add one cycle before the first write_enb_reg.
- soft_reset_i:
  - Goes high in the cycle after the TIMEOUT-th consecutive edge at which vld_out_i=1 and read_enb_i=0.
  - Stays high exactly one cycle.
  - If the stall persists after that pulse, the next pulse comes TIMEOUT edges later.
- Any read_enb_i=1 or empty_i=1 at an edge restarts the count. A read on the same edge the count would expire suppresses the pulse.
- reset mid-count: the counter clears and any pending or active soft_reset drops on the next edge.
- addr_q changing mid-packet is legal. It redirects writes from the next cycle; protocol ordering is the FSM's responsibility.
- Channels are independent: simultaneous timeouts on several ports produce simultaneous pulses.

## Test plan
- Reset, then data_in=01 with detect_add=1 for one cycle, then write_enb_reg=1 -> write_enb=010 from the following cycle; with full_1=1, fifo_full=1.
- Address 11 latched, write_enb_reg=1 -> write_enb=000, fifo_full=0 regardless of full_0..2.
- Hold empty_2=0 and read_enb_2=0 for 30 edges -> soft_reset_2=1 for exactly one cycle after edge 30, then 0; other ports stay 0.
- Same stall, but read_enb_2=1 at edge 29 -> no pulse; the count restarts and the pulse appears only after 30 further stalled edges.
- Stall port 0 for 15 edges, assert reset for one cycle, then continue stalling -> soft_reset_0 fires 30 edges after reset deasserts, not 15.
- detect_add=1 with data_in=10 and write_enb_reg=1 in the same cycle, previous addr_q=00 -> write_enb=001 that cycle, 100 next cycle.
